// File: rtl/lsq_pkg.sv
// Shared types and sizing for the LSQ store side.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: queue geometry (SQ_DEPTH/ADDR_W/DATA_W/BR_MASK_W and derived widths),
// ptr_t (index plus wrap bit) and sq_entry_t (one store queue slot).
package lsq_pkg;

  localparam int SQ_DEPTH  = 8;   // entries, power of 2
  localparam int ADDR_W    = 64;  // byte address width
  localparam int DATA_W    = 64;  // store/load data width, multiple of 8
  localparam int BR_MASK_W = 4;   // branch-mask width

  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFS_W = $clog2(BE_W);  // byte-offset bits below the word address

  // Queue pointer; the extra wrap bit tells full from empty when indices match.
  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  typedef struct packed {
    logic                 vld;       // slot allocated
    logic                 addr_vld;  // LSU has written addr/data/be
    logic                 retired;   // ROB committed; eligible to drain
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
    logic [BE_W-1:0]      be;
    logic [BR_MASK_W-1:0] br_mask;
  } sq_entry_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    logic [IDX_W:0] v;
    v = p + (IDX_W+1)'(1);
    return ptr_t'(v);
  endfunction

  // Number of slots from 'older' up to (not including) 'younger', wrap-aware.
  function automatic logic [IDX_W:0] ptr_dist(input ptr_t younger, input ptr_t older);
    return younger - older;
  endfunction

endpackage

// File: rtl/sq_age_sel.sv
// Age-ordered selector: youngest matching entry inside [head, head+win_len).
// Latency: purely combinational.
// Backpressure: none; the caller turns 'unknown'/partial matches into a load replay.
//
// Ports: match_i/unk_i  per-physical-slot match and address-unknown flags
//        head_i         physical index of the oldest slot
//        win_len_i      number of slots in the window (0..SQ_DEPTH)
//        sel_idx_o      physical index of youngest match, found_o when valid
//        unknown_o      some slot in the window has an unresolved address
module sq_age_sel
  import lsq_pkg::*;
(
  input  logic [SQ_DEPTH-1:0] match_i,
  input  logic [SQ_DEPTH-1:0] unk_i,
  input  logic [IDX_W-1:0]    head_i,
  input  logic [IDX_W:0]      win_len_i,
  output logic [IDX_W-1:0]    sel_idx_o,
  output logic                found_o,
  output logic                unknown_o
);

  // After rotation bit 0 is the oldest slot, so age order equals bit order.
  logic [SQ_DEPTH-1:0] rot_match;
  logic [SQ_DEPTH-1:0] rot_unk;
  logic [SQ_DEPTH-1:0] win_mask;
  logic [IDX_W-1:0]    sel_ofs;

  always_comb begin
    rot_match = '0;
    rot_unk   = '0;
    win_mask  = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      rot_match[i] = match_i[head_i + IDX_W'(i)];
      rot_unk[i]   = unk_i[head_i + IDX_W'(i)];
      win_mask[i]  = ((IDX_W+1)'(i) < win_len_i);
    end
  end

  // Ascending scan: the last hit wins, which is the youngest one.
  always_comb begin
    found_o = 1'b0;
    sel_ofs = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (rot_match[i] && win_mask[i]) begin
        found_o = 1'b1;
        sel_ofs = IDX_W'(i);
      end
    end
  end

  assign sel_idx_o = head_i + sel_ofs;
  assign unknown_o = |(rot_unk & win_mask);

endmodule

// File: rtl/sq_fwd_queue.sv
// Store queue with byte-enable store-to-load forwarding, retire and Dcache drain.
// Latency: forwarding is combinational; state updates land on the next clk edge.
// Backpressure: sq_full_o stalls dispatch; drain holds head until dc_st_ack_i; loads replay on fwd_stall_o.
//
// Ports: dp_*  dispatch allocation (sq_tail_o/sq_full_o back to RS)
//        st_*  LSU store execute (address/data/byte-enable capture)
//        ld_*  load forwarding probe -> fwd_hit_o/fwd_data_o/fwd_stall_o
//        rob_st_retire_i  commit oldest unretired store
//        dc_st_*  drain handshake to Dcache
//        br_*  branch recovery (tail restore) and correct-resolution mask clear
// Geometry comes from lsq_pkg.
module sq_fwd_queue
  import lsq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dp_en_i,
  input  logic [BR_MASK_W-1:0] dp_br_mask_i,
  output logic [IDX_W:0]       sq_tail_o,
  output logic                 sq_full_o,
  input  logic                 st_vld_i,
  input  logic [IDX_W-1:0]     st_idx_i,
  input  logic [ADDR_W-1:0]    st_addr_i,
  input  logic [DATA_W-1:0]    st_data_i,
  input  logic [BE_W-1:0]      st_be_i,
  input  logic                 ld_vld_i,
  input  logic [ADDR_W-1:0]    ld_addr_i,
  input  logic [BE_W-1:0]      ld_be_i,
  input  logic [IDX_W:0]       ld_pos_i,
  output logic                 fwd_hit_o,
  output logic [DATA_W-1:0]    fwd_data_o,
  output logic                 fwd_stall_o,
  input  logic                 rob_st_retire_i,
  output logic                 dc_st_req_o,
  output logic [ADDR_W-1:0]    dc_st_addr_o,
  output logic [DATA_W-1:0]    dc_st_data_o,
  output logic [BE_W-1:0]      dc_st_be_o,
  input  logic                 dc_st_ack_i,
  input  logic                 br_recovery_i,
  input  logic [IDX_W:0]       br_tail_rec_i,
  input  logic                 br_correct_i,
  input  logic [BR_MASK_W-1:0] br_tag_fix_i
);

  sq_entry_t sq_q [SQ_DEPTH];
  sq_entry_t sq_d [SQ_DEPTH];

  // head (drain) <= ret (next to retire) <= tail (next to allocate)
  ptr_t head_q, head_d;
  ptr_t ret_q,  ret_d;
  ptr_t tail_q, tail_d;

  ptr_t                rec_ptr;
  ptr_t                ld_pos;
  logic                full;
  logic                dc_req;
  logic [IDX_W:0]      kill_cnt;
  logic [SQ_DEPTH-1:0] kill;
  logic [SQ_DEPTH-1:0] match_vec;
  logic [SQ_DEPTH-1:0] unk_vec;
  logic [IDX_W:0]      win_len;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                sel_unknown;
  logic                sel_covers;
  logic [BR_MASK_W-1:0] fix_mask;

  assign rec_ptr = ptr_t'(br_tail_rec_i);
  assign ld_pos  = ptr_t'(ld_pos_i);

  assign full   = (tail_q.idx == head_q.idx) && (tail_q.wrap != head_q.wrap);
  assign dc_req = sq_q[head_q.idx].vld & sq_q[head_q.idx].retired;

  // Slots in [rec_ptr, tail_q) are wrong-path: offset from rec_ptr below the squash count.
  always_comb begin
    kill     = '0;
    kill_cnt = ptr_dist(tail_q, rec_ptr);
    for (int i = 0; i < SQ_DEPTH; i++) begin
      kill[i] = ({1'b0, IDX_W'(i) - rec_ptr.idx} < kill_cnt);
    end
  end

  assign fix_mask = br_correct_i ? br_tag_fix_i : '0;

  always_comb begin
    sq_d   = sq_q;
    head_d = head_q;
    ret_d  = ret_q;
    tail_d = tail_q;

    if (dc_req && dc_st_ack_i) begin
      sq_d[head_q.idx].vld     = 1'b0;
      sq_d[head_q.idx].retired = 1'b0;
      head_d                   = ptr_inc(head_q);
    end

    if (rob_st_retire_i) begin
      sq_d[ret_q.idx].retired = 1'b1;
      ret_d                   = ptr_inc(ret_q);
    end

    if (st_vld_i) begin
      sq_d[st_idx_i].addr     = st_addr_i;
      sq_d[st_idx_i].data     = st_data_i;
      sq_d[st_idx_i].be       = st_be_i;
      sq_d[st_idx_i].addr_vld = 1'b1;
    end

    if (br_recovery_i) begin
      // Recovery wins over both dispatch and a same-cycle correct resolution.
      tail_d = rec_ptr;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (kill[i]) begin
          sq_d[i].vld = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sq_d[i].br_mask = sq_q[i].br_mask & ~fix_mask;
      end
      if (dp_en_i && !full) begin
        sq_d[tail_q.idx].vld      = 1'b1;
        sq_d[tail_q.idx].addr_vld = 1'b0;
        sq_d[tail_q.idx].retired  = 1'b0;
        sq_d[tail_q.idx].addr     = '0;
        sq_d[tail_q.idx].data     = '0;
        sq_d[tail_q.idx].be       = '0;
        // A branch resolving this cycle must not leave its bit on the new store.
        sq_d[tail_q.idx].br_mask  = dp_br_mask_i & ~fix_mask;
        tail_d                    = ptr_inc(tail_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      ret_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sq_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      ret_q  <= ret_d;
      tail_q <= tail_d;
      sq_q   <= sq_d;
    end
  end

  // Forwarding only sees registered state, so a same-cycle store write still looks unknown.
  always_comb begin
    match_vec = '0;
    unk_vec   = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      match_vec[i] = sq_q[i].vld && sq_q[i].addr_vld &&
                     (sq_q[i].addr[ADDR_W-1:OFS_W] == ld_addr_i[ADDR_W-1:OFS_W]) &&
                     (|(sq_q[i].be & ld_be_i));
      unk_vec[i]   = sq_q[i].vld && !sq_q[i].addr_vld;
    end
  end

  // Older window is [head, ld_pos); an equal pointer (wrap included) means no older stores.
  assign win_len = ptr_dist(ld_pos, head_q);

  sq_age_sel u_age_sel (
    .match_i   (match_vec),
    .unk_i     (unk_vec),
    .head_i    (head_q.idx),
    .win_len_i (win_len),
    .sel_idx_o (sel_idx),
    .found_o   (sel_found),
    .unknown_o (sel_unknown)
  );

  assign sel_covers  = ((ld_be_i & ~sq_q[sel_idx].be) == '0);
  assign fwd_hit_o   = ld_vld_i && !sel_unknown && sel_found && sel_covers;
  assign fwd_stall_o = ld_vld_i && (sel_unknown || (sel_found && !sel_covers));
  assign fwd_data_o  = fwd_hit_o ? sq_q[sel_idx].data : '0;

  // Byte offset inside the word never takes part in the word compare.
  logic unused_ld_ofs;
  assign unused_ld_ofs = ^ld_addr_i[OFS_W-1:0];

  assign sq_tail_o    = tail_q;
  assign sq_full_o    = full;
  assign dc_st_req_o  = dc_req;
  assign dc_st_addr_o = dc_req ? sq_q[head_q.idx].addr : '0;
  assign dc_st_data_o = dc_req ? sq_q[head_q.idx].data : '0;
  assign dc_st_be_o   = dc_req ? sq_q[head_q.idx].be   : '0;

  // A store can only commit once the LSU has supplied its address.
  logic ret_bad;
  assign ret_bad = rob_st_retire_i && !sq_q[ret_q.idx].addr_vld;

  ap_retire_needs_addr: assert property (@(posedge clk) disable iff (!rst_n) !ret_bad);

endmodule

// File: tb/tb_sq_fwd_queue.sv
// Bench for sq_fwd_queue: directed scenarios plus constrained-random traffic.
// Latency: outputs compared at the falling edge against a queue-based model.
// Backpressure: stimulus respects sq_full_o, retire legality and ack-only-on-request.
module tb_sq_fwd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dp_en_i;
  logic [3:0]  dp_br_mask_i;
  logic [3:0]  sq_tail_o;
  logic        sq_full_o;
  logic        st_vld_i;
  logic [2:0]  st_idx_i;
  logic [63:0] st_addr_i;
  logic [63:0] st_data_i;
  logic [7:0]  st_be_i;
  logic        ld_vld_i;
  logic [63:0] ld_addr_i;
  logic [7:0]  ld_be_i;
  logic [3:0]  ld_pos_i;
  logic        fwd_hit_o;
  logic [63:0] fwd_data_o;
  logic        fwd_stall_o;
  logic        rob_st_retire_i;
  logic        dc_st_req_o;
  logic [63:0] dc_st_addr_o;
  logic [63:0] dc_st_data_o;
  logic [7:0]  dc_st_be_o;
  logic        dc_st_ack_i;
  logic        br_recovery_i;
  logic [3:0]  br_tail_rec_i;
  logic        br_correct_i;
  logic [3:0]  br_tag_fix_i;

  always #5 clk = ~clk;

  sq_fwd_queue dut (
    .clk(clk), .rst_n(rst_n),
    .dp_en_i(dp_en_i), .dp_br_mask_i(dp_br_mask_i),
    .sq_tail_o(sq_tail_o), .sq_full_o(sq_full_o),
    .st_vld_i(st_vld_i), .st_idx_i(st_idx_i), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i),
    .ld_vld_i(ld_vld_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i), .ld_pos_i(ld_pos_i),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .fwd_stall_o(fwd_stall_o),
    .rob_st_retire_i(rob_st_retire_i),
    .dc_st_req_o(dc_st_req_o), .dc_st_addr_o(dc_st_addr_o),
    .dc_st_data_o(dc_st_data_o), .dc_st_be_o(dc_st_be_o), .dc_st_ack_i(dc_st_ack_i),
    .br_recovery_i(br_recovery_i), .br_tail_rec_i(br_tail_rec_i),
    .br_correct_i(br_correct_i), .br_tag_fix_i(br_tag_fix_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: program-ordered list of live stores, oldest first.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    bit          av;
    bit          rtd;
    logic [3:0]  mask;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_head = 0;  // head pointer value, 0..15 including wrap bit
  int     m_ret  = 0;  // retired-but-undrained stores at the front of mq

  task automatic m_fwd(input logic [63:0] a, input logic [7:0] be, input logic [3:0] pos,
                       output bit hit, output bit stall, output logic [63:0] data);
    int n;
    n = (int'(pos) - m_head + 16) % 16;
    if (n > mq.size()) n = mq.size();
    hit = 0; stall = 0; data = '0;
    for (int k = 0; k < n; k++) if (!mq[k].av) stall = 1;
    if (!stall) begin
      for (int k = n - 1; k >= 0; k--) begin
        if (mq[k].addr[63:3] == a[63:3] && (mq[k].be & be) != 8'h00) begin
          if ((be & ~mq[k].be) == 8'h00) begin
            hit = 1; data = mq[k].data;
          end else begin
            stall = 1;
          end
          break;
        end
      end
    end
  endtask

  task automatic model_step();
    int sz, k, r;
    bit req;
    m_ent_t e;
    sz  = mq.size();
    req = (sz > 0) && mq[0].rtd;
    if (st_vld_i) begin
      k = (int'(st_idx_i) - (m_head % 8) + 8) % 8;
      if (k < sz) begin
        mq[k].addr = st_addr_i; mq[k].data = st_data_i; mq[k].be = st_be_i; mq[k].av = 1;
      end
    end
    if (rob_st_retire_i && m_ret < sz) begin
      mq[m_ret].rtd = 1; m_ret++;
    end
    if (br_recovery_i) begin
      r = (int'(br_tail_rec_i) - m_head + 16) % 16;
      while (mq.size() > r) void'(mq.pop_back());
    end else begin
      if (dp_en_i && sz < 8) begin
        e.addr = '0; e.data = '0; e.be = '0; e.av = 0; e.rtd = 0; e.mask = dp_br_mask_i;
        mq.push_back(e);
      end
      if (br_correct_i) foreach (mq[j]) mq[j].mask = mq[j].mask & ~br_tag_fix_i;
    end
    if (req && dc_st_ack_i) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % 16;
      m_ret--;
    end
  endtask

  task automatic check_outputs();
    int sz;
    bit hit, stall;
    logic [63:0] data;
    sz = mq.size();
    chk("tail", 64'(sq_tail_o), 64'((m_head + sz) % 16));
    chk("full", 64'(sq_full_o), 64'(sz == 8));
    chk("dc_req", 64'(dc_st_req_o), 64'(sz > 0 && mq[0].rtd));
    if (sz > 0 && mq[0].rtd) begin
      chk("dc_addr", dc_st_addr_o, mq[0].addr);
      chk("dc_data", dc_st_data_o, mq[0].data);
      chk("dc_be", 64'(dc_st_be_o), 64'(mq[0].be));
    end
    if (ld_vld_i) begin
      m_fwd(ld_addr_i, ld_be_i, ld_pos_i, hit, stall, data);
      chk("fwd_hit", 64'(fwd_hit_o), 64'(hit));
      chk("fwd_stall", 64'(fwd_stall_o), 64'(stall));
      if (hit) chk("fwd_data", fwd_data_o, data);
    end else begin
      chk("fwd_hit_idle", 64'(fwd_hit_o), 64'h0);
      chk("fwd_stall_idle", 64'(fwd_stall_o), 64'h0);
      chk("fwd_data_idle", fwd_data_o, 64'h0);
    end
  endtask

  task automatic idle();
    dp_en_i = 0; dp_br_mask_i = '0; st_vld_i = 0; st_idx_i = '0; st_addr_i = '0;
    st_data_i = '0; st_be_i = '0; ld_vld_i = 0; ld_addr_i = '0; ld_be_i = '0;
    ld_pos_i = '0; rob_st_retire_i = 0; dc_st_ack_i = 0; br_recovery_i = 0;
    br_tail_rec_i = '0; br_correct_i = 0; br_tag_fix_i = '0;
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    mq.delete(); m_head = 0; m_ret = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int idx, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    st_vld_i = 1; st_idx_i = 3'(idx); st_addr_i = a; st_data_i = d; st_be_i = be;
    step();
    st_vld_i = 0;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] w;
    case ($urandom_range(0, 2))
      0:       w = 64'h100;
      1:       w = 64'h108;
      default: w = 64'h200;
    endcase
    return w | 64'($urandom_range(0, 7));
  endfunction

  function automatic logic [7:0] rand_be();
    case ($urandom_range(0, 6))
      0:       return 8'hFF;
      1:       return 8'h0F;
      2:       return 8'hF0;
      3:       return 8'h01;
      4:       return 8'h3C;
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic rand_inputs();
    int sz, k, lo, r;
    int cand[$];
    bit req;
    idle();
    sz  = mq.size();
    req = (sz > 0) && mq[0].rtd;
    if ($urandom_range(0, 99) < 45) begin
      dp_en_i = 1; dp_br_mask_i = 4'($urandom);
    end
    for (int j = 0; j < sz; j++) if (!mq[j].av) cand.push_back(j);
    if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
      k = cand[$urandom_range(0, cand.size() - 1)];
      st_vld_i = 1; st_idx_i = 3'((m_head + k) % 8); st_addr_i = rand_addr();
      st_data_i = {$urandom, $urandom}; st_be_i = rand_be();
    end
    if (m_ret < sz && mq[m_ret].av && $urandom_range(0, 99) < 40) rob_st_retire_i = 1;
    if (req && $urandom_range(0, 99) < 50) dc_st_ack_i = 1;
    if ($urandom_range(0, 99) < 4) begin
      lo = m_ret + int'(rob_st_retire_i);
      r  = int'($urandom_range(lo, sz));
      br_recovery_i = 1; br_tail_rec_i = 4'((m_head + r) % 16);
    end
    if ($urandom_range(0, 99) < 10) begin
      br_correct_i = 1; br_tag_fix_i = 4'(1 << $urandom_range(0, 3));
    end
    if ($urandom_range(0, 99) < 70) begin
      ld_vld_i = 1; ld_pos_i = 4'((m_head + int'($urandom_range(0, sz))) % 16);
      ld_addr_i = rand_addr(); ld_be_i = rand_be();
    end
  endtask

  initial begin
    idle();
    do_reset();
    chk("rst_tail", 64'(sq_tail_o), 64'h0);
    chk("rst_full", 64'(sq_full_o), 64'h0);
    chk("rst_req", 64'(dc_st_req_o), 64'h0);

    // 1) asynchronous reset while a drain request is pending
    dp_en_i = 1; step(); dp_en_i = 0;
    store(0, 64'h100, 64'h55, 8'hFF);
    rob_st_retire_i = 1; step(); rob_st_retire_i = 0;
    ld_vld_i = 1; ld_pos_i = 4'd1; ld_addr_i = 64'h100; ld_be_i = 8'h0F;
    #1;
    chk("t1_req_before", 64'(dc_st_req_o), 64'h1);
    chk("t1_hit_before", 64'(fwd_hit_o), 64'h1);
    rst_n = 0;
    #1;
    chk("t1_req_rst", 64'(dc_st_req_o), 64'h0);
    chk("t1_hit_rst", 64'(fwd_hit_o), 64'h0);
    chk("t1_stall_rst", 64'(fwd_stall_o), 64'h0);
    chk("t1_tail_rst", 64'(sq_tail_o), 64'h0);
    do_reset();

    // 2) fill to full, overflow dispatch ignored, one drain frees a slot
    for (int i = 0; i < 8; i++) begin
      dp_en_i = 1; dp_br_mask_i = '0; step();
    end
    chk("t2_full", 64'(sq_full_o), 64'h1);
    chk("t2_tail", 64'(sq_tail_o), 64'h8);
    step();
    dp_en_i = 0;
    chk("t2_tail_hold", 64'(sq_tail_o), 64'h8);
    store(0, 64'h40, 64'h1234, 8'hFF);
    rob_st_retire_i = 1; step(); rob_st_retire_i = 0;
    dc_st_ack_i = 1; step(); dc_st_ack_i = 0;
    chk("t2_not_full", 64'(sq_full_o), 64'h0);
    do_reset();

    // 3) youngest overlapping store wins; partial cover stalls
    repeat (2) begin dp_en_i = 1; step(); end
    dp_en_i = 0;
    store(0, 64'h100, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    store(1, 64'h100, 64'h0000_0000_1122_3344, 8'h0F);
    ld_vld_i = 1; ld_pos_i = 4'd2; ld_addr_i = 64'h100; ld_be_i = 8'h0F;
    #1;
    chk("t3_hit", 64'(fwd_hit_o), 64'h1);
    chk("t3_data", fwd_data_o & 64'hFFFF_FFFF, 64'h1122_3344);
    ld_be_i = 8'hFF;
    #1;
    chk("t3_partial_stall", 64'(fwd_stall_o), 64'h1);
    chk("t3_partial_nohit", 64'(fwd_hit_o), 64'h0);
    step();
    do_reset();

    // 4) unknown older address stalls, including the cycle its store is written
    dp_en_i = 1; step(); dp_en_i = 0;
    ld_vld_i = 1; ld_pos_i = 4'd1; ld_addr_i = 64'h900; ld_be_i = 8'hFF;
    #1;
    chk("t4_unknown_stall", 64'(fwd_stall_o), 64'h1);
    st_vld_i = 1; st_idx_i = 3'd0; st_addr_i = 64'h100; st_data_i = 64'h77; st_be_i = 8'hFF;
    #1;
    chk("t4_same_cycle_stall", 64'(fwd_stall_o), 64'h1);
    step();
    st_vld_i = 0;
    #1;
    chk("t4_resolved_stall", 64'(fwd_stall_o), 64'h0);
    chk("t4_resolved_hit", 64'(fwd_hit_o), 64'h0);
    do_reset();

    // 5) drain held by a slow Dcache, then back-to-back
    repeat (2) begin dp_en_i = 1; step(); end
    dp_en_i = 0;
    store(0, 64'h300, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    store(1, 64'h308, 64'hCAFE_F00D_0000_0002, 8'h0F);
    rob_st_retire_i = 1; step(); step(); rob_st_retire_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_req_hold", 64'(dc_st_req_o), 64'h1);
      chk("t5_addr_hold", dc_st_addr_o, 64'h300);
      chk("t5_data_hold", dc_st_data_o, 64'hDEAD_BEEF_0000_0001);
      step();
    end
    dc_st_ack_i = 1; step(); dc_st_ack_i = 0;
    chk("t5_next_req", 64'(dc_st_req_o), 64'h1);
    chk("t5_next_addr", dc_st_addr_o, 64'h308);
    chk("t5_next_be", 64'(dc_st_be_o), 64'h0F);
    dc_st_ack_i = 1; step(); dc_st_ack_i = 0;
    chk("t5_empty_req", 64'(dc_st_req_o), 64'h0);
    do_reset();

    // 6) recovery squashes the wrong path; correct clears only mask bits
    dp_en_i = 1;
    dp_br_mask_i = 4'b0010; step();
    dp_br_mask_i = 4'b1010; step();
    dp_br_mask_i = 4'b0001; step(); step(); step();
    dp_en_i = 0;
    br_recovery_i = 1; br_tail_rec_i = 4'd2; step(); br_recovery_i = 0;
    chk("t6_tail", 64'(sq_tail_o), 64'h2);
    for (int i = 0; i < 5; i++) chk("t6_vld", 64'(dut.sq_q[i].vld), 64'(i < 2));
    br_correct_i = 1; br_tag_fix_i = 4'b0010; step(); br_correct_i = 0;
    chk("t6_mask0", 64'(dut.sq_q[0].br_mask), 64'h0);
    chk("t6_mask1", 64'(dut.sq_q[1].br_mask), 64'h8);
    chk("t6_vld_kept", 64'(dut.sq_q[1].vld), 64'h1);
    chk("t6_tail_kept", 64'(sq_tail_o), 64'h2);
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
